instr_prefetch: RTL and testbench
=================================

// Module: instr_prefetch
// PURPOSE
//  Instruction fetch stage upstream of the accumulator processor's control unit and decode split.
//  Owns the fetch PC and issues single-byte reads to instruction memory.
//  Buffers returned bytes in a small FIFO and presents them with a valid/ready handshake.
//  Each presented byte is split into opcode[7:5] and immediate[4:0].
//  A taken branch flushes the FIFO and redirects fetch to the target address.
// PARAMETERS
//  DEPTH    2      prefetch FIFO entries (power of 2, >=2)
//  ADDR_W   8      fetch address width; PC wraps modulo 2^ADDR_W
//  RESET_PC 8'h00  fetch PC value after reset
// PORTS
//  clk           in   1       clock, all state updates on rising edge
//  rst_n         in   1       asynchronous active-low reset
//  mem_req       out  1       read request to instruction memory
//  mem_addr      out  ADDR_W  read address; held stable while mem_req=1 and no ack
//  mem_ack       in   1       memory returns mem_rdata this cycle; never in the same cycle as the request's first assertion
//  mem_rdata     in   8       instruction byte, valid when mem_ack=1
//  brnch         in   1       taken branch, single-cycle pulse
//  brnch_target  in   ADDR_W  new fetch address, sampled when brnch=1
//  instr_valid   out  1       head FIFO entry valid
//  instr_ready   in   1       control unit consumes head when instr_valid & instr_ready
//  opcode        out  3       head byte [7:5]
//  immediate     out  5       head byte [4:0]
//  instr_pc      out  ADDR_W  address the head byte was fetched from
// BEHAVIOUR
//  Reset (async, rst_n=0) sets the following values; they hold until the first clk edge after release:
//   - fetch_pc=RESET_PC, FIFO empty, no request outstanding, discard flag clear
//   - mem_req=0, instr_valid=0, opcode=0, immediate=0, instr_pc=0
//  Request rule:
//   - At most one request is outstanding.
//   - mem_req rises the cycle after (FIFO entries + outstanding) < DEPTH and none is outstanding.
//   - mem_req stays high until the ack cycle.
//   - mem_addr = fetch_pc for the whole request.
//  On mem_ack:
//   - mem_req drops.
//   - The byte and its address are pushed into the FIFO, unless discard is set.
//   - fetch_pc increments by 1, wrapping 8'hFF -> 8'h00.
//   - Minimum fetch latency: request cycle N, ack at N+1 or later, instr_valid at N+2.
//  FIFO:
//   - Head drives opcode, immediate and instr_pc combinationally from registered storage.
//   - Outputs are 0 when empty.
//   - Pop on instr_valid & instr_ready. Push and pop in the same cycle are both honoured and the count is unchanged.
//   - Never overflows, because requests are gated by the credit rule above.
//  Branch (brnch=1 at edge):
//   - FIFO is emptied and instr_valid=0 next cycle.
//   - fetch_pc=brnch_target.
//   - A pop in that same cycle is ignored.
//   - If a request is outstanding: mem_req drops immediately (registered next cycle) and discard is set.
//   - The next mem_ack clears discard and its data is dropped. No new request until that ack.
//   - If mem_ack coincides with brnch: the data is dropped, discard is not set, and the new request can go out next cycle.
//   - brnch while discard is already set: the target is updated and discard stays set.
//  Reset mid-request: the outstanding request is abandoned. The memory must not ack after rst_n=0.
// TESTING
//  1 Reset, mem acks 1 cycle after req with mem[a]=a+8'h20, ready=1:
//    -> addresses 00,01,02.. in order; opcode/immediate of 8'h20 = 3'b001/5'b00000 at instr_pc 00.
//  2 ready=0 for 10 cycles:
//    -> exactly DEPTH=2 bytes buffered, mem_req stays 0, instr_valid=1 holding the PC-00 byte.
//  3 brnch pulse, target 8'h40, while a request to 8'h05 is outstanding with ack 3 cycles later:
//    -> ack data dropped, next mem_addr=8'h40, no stale byte ever valid.
//  4 brnch coincident with mem_ack:
//    -> data dropped, request to target issued the following cycle.
//  5 fetch_pc=8'hFF, ready=1:
//    -> next request address 8'h00, instr_pc sequence FF,00.
//  6 rst_n low for 1 cycle mid-stream with 2 entries buffered:
//    -> instr_valid=0 and mem_req=0 immediately (async); restart fetch at RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_if.sv
// Fetch-stage bus bundle: instruction memory read port, branch redirect and the
// valid/ready instruction handoff to the control unit.
interface instr_prefetch_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              brnch;
  logic [ADDR_W-1:0] brnch_target;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        opcode;
  logic [4:0]        immediate;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, opcode, immediate, instr_pc,
    input  mem_ack, mem_rdata, brnch, brnch_target, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, opcode, immediate, instr_pc,
    output mem_ack, mem_rdata, brnch, brnch_target, instr_ready
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch: owns the fetch PC, issues one byte read at a time and
// buffers returned bytes in a small FIFO split into opcode/immediate.
module instr_prefetch #(
  parameter int unsigned       DEPTH    = 2,
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_prefetch_if.master bus
);

  localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [7:0]        data;
  } entry_t;

  // ST_DISCARD: a request was abandoned by a branch and its ack is still owed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic   w_valid;
  logic   w_push;
  logic   w_pop;
  entry_t w_head;
  entry_t w_wr_entry;

  assign w_valid    = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_pop      = w_valid & bus.instr_ready & ~bus.brnch;
  assign w_push     = bus.mem_ack & (r_state == ST_REQ) & ~bus.brnch;
  assign w_wr_entry = '{pc: r_fetch_pc, data: bus.mem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Credit rule uses registered occupancy, so a request rises one cycle after space frees.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (r_count < DEPTH_C) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_ack) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.brnch) begin
          w_state_nxt = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (bus.mem_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Fetch PC only advances on accepted data; a branch always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (bus.brnch) begin
      r_fetch_pc <= bus.brnch_target;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.brnch) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign bus.mem_req     = (r_state == ST_REQ);
  assign bus.mem_addr    = r_fetch_pc;
  assign bus.instr_valid = w_valid;
  assign bus.opcode      = w_valid ? w_head.data[7:5] : 3'd0;
  assign bus.immediate   = w_valid ? w_head.data[4:0] : 5'd0;
  assign bus.instr_pc    = w_valid ? w_head.pc : '0;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: memory model returns mem[a]=a+8'h20 after a
// programmable latency; consumed instructions and issued requests are logged.
module tb_instr_prefetch;

  localparam int unsigned ADDR_W = 8;

  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] op;
    logic [4:0] imm;
  } cons_t;

  logic clk = 1'b0;
  logic rst_n;

  instr_prefetch_if #(.ADDR_W(ADDR_W)) bus ();

  instr_prefetch #(
    .DEPTH   (2),
    .ADDR_W  (ADDR_W),
    .RESET_PC(8'h00)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned lat      = 1;
  cons_t       cons_log [$];
  logic [7:0]  req_log  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Memory: latches the address on a request's first cycle, acks 'lat' cycles later.
  logic        m_pend = 1'b0;
  int unsigned m_cnt  = 0;
  logic [7:0]  m_addr = 8'h00;
  always @(negedge clk) begin
    bus.mem_ack = 1'b0;
    if (!rst_n) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_cnt++;
      if (bus.mem_req) check("addr_hold", 32'(bus.mem_addr), 32'(m_addr));
      if (m_cnt >= lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = m_addr + 8'h20;
        m_pend        = 1'b0;
      end
    end else if (bus.mem_req) begin
      m_pend = 1'b1;
      m_cnt  = 0;
      m_addr = bus.mem_addr;
      req_log.push_back(bus.mem_addr);
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && bus.instr_valid && bus.instr_ready && !bus.brnch)
      cons_log.push_back('{pc: bus.instr_pc, op: bus.opcode, imm: bus.immediate});
  end

  function automatic logic [7:0] req_at(input int idx);
    return (idx < req_log.size()) ? req_log[idx] : 8'hEE;
  endfunction

  task automatic check_cons(input string tag, input int idx, input logic [7:0] pc,
                            input logic [2:0] op, input logic [4:0] imm);
    cons_t e;
    e = (idx < cons_log.size()) ? cons_log[idx] : '1;
    check({tag, "_pc"},  32'(e.pc),  32'(pc));
    check({tag, "_op"},  32'(e.op),  32'(op));
    check({tag, "_imm"}, 32'(e.imm), 32'(imm));
  endtask

  task automatic wait_req(input logic [7:0] a);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = bus.mem_req && (bus.mem_addr == a);
    end
    check("wait_req", 32'(hit), 32'd1);
  endtask

  task automatic do_reset(input int unsigned l);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    req_log.delete();
    cons_log.delete();
    lat = l;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int stale;
    rst_n            = 1'b0;
    bus.brnch        = 1'b0;
    bus.brnch_target = 8'h00;
    bus.instr_ready  = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_req",   32'(bus.mem_req),     32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_op",    32'(bus.opcode),      32'd0);
    check("rst_imm",   32'(bus.immediate),   32'd0);
    check("rst_pc",    32'(bus.instr_pc),    32'd0);
    rst_n = 1'b1;

    // 1: sequential fetch, minimum latency
    @(negedge clk);
    check("t1_req_n",    32'(bus.mem_req),     32'd1);
    check("t1_addr_n",   32'(bus.mem_addr),    32'h00);
    check("t1_valid_n",  32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    check("t1_req_n1",   32'(bus.mem_req),     32'd1);
    check("t1_valid_n1", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_n2", 32'(bus.instr_valid), 32'd1);
    check("t1_pc_n2",    32'(bus.instr_pc),    32'h00);
    check("t1_op_n2",    32'(bus.opcode),      32'd1);
    check("t1_imm_n2",   32'(bus.immediate),   32'd0);
    check("t1_req_n2",   32'(bus.mem_req),     32'd0);
    repeat (20) @(negedge clk);
    check("t1_req0", 32'(req_at(0)), 32'h00);
    check("t1_req1", 32'(req_at(1)), 32'h01);
    check("t1_req2", 32'(req_at(2)), 32'h02);
    check("t1_req3", 32'(req_at(3)), 32'h03);
    check_cons("t1_c0", 0, 8'h00, 3'd1, 5'd0);
    check_cons("t1_c1", 1, 8'h01, 3'd1, 5'd1);
    check_cons("t1_c2", 2, 8'h02, 3'd1, 5'd2);

    // 2: consumer stalled, FIFO fills to DEPTH and fetch stops
    bus.instr_ready = 1'b0;
    do_reset(1);
    repeat (12) @(negedge clk);
    check("t2_nreq",  32'(req_log.size()),   32'd2);
    check("t2_req",   32'(bus.mem_req),      32'd0);
    check("t2_valid", 32'(bus.instr_valid),  32'd1);
    check("t2_pc",    32'(bus.instr_pc),     32'h00);
    check("t2_op",    32'(bus.opcode),       32'd1);
    check("t2_imm",   32'(bus.immediate),    32'd0);
    bus.instr_ready = 1'b1;
    repeat (12) @(negedge clk);
    check_cons("t2_c0", 0, 8'h00, 3'd1, 5'd0);
    check_cons("t2_c1", 1, 8'h01, 3'd1, 5'd1);
    check("t2_req2", 32'(req_at(2)), 32'h02);

    // 3: branch while the request to 05 is outstanding, ack 3 cycles later
    do_reset(3);
    wait_req(8'h05);
    bus.brnch        = 1'b1;
    bus.brnch_target = 8'h40;
    @(negedge clk);
    bus.brnch = 1'b0;
    check("t3_req",   32'(bus.mem_req),     32'd0);
    check("t3_valid", 32'(bus.instr_valid), 32'd0);
    repeat (30) @(negedge clk);
    check("t3_req5", 32'(req_at(5)), 32'h05);
    check("t3_req6", 32'(req_at(6)), 32'h40);
    check_cons("t3_c4", 4, 8'h04, 3'd1, 5'd4);
    check_cons("t3_c5", 5, 8'h40, 3'd3, 5'd0);
    stale = 0;
    foreach (cons_log[i]) if (cons_log[i].pc == 8'h05) stale++;
    check("t3_stale", 32'(stale), 32'd0);

    // 4: branch coincident with the ack of the request to 03
    do_reset(1);
    wait_req(8'h03);
    @(negedge clk);
    bus.brnch        = 1'b1;
    bus.brnch_target = 8'h80;
    @(negedge clk);
    bus.brnch = 1'b0;
    check("t4_req_a",   32'(bus.mem_req),     32'd0);
    check("t4_valid_a", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    check("t4_req_b",  32'(bus.mem_req),  32'd1);
    check("t4_addr_b", 32'(bus.mem_addr), 32'h80);
    repeat (10) @(negedge clk);
    check("t4_req4", 32'(req_at(4)), 32'h80);
    check_cons("t4_c2", 2, 8'h02, 3'd1, 5'd2);
    check_cons("t4_c3", 3, 8'h80, 3'd5, 5'd0);

    // 5: flush a full FIFO with a branch to FF (same-cycle pop ignored), then wrap
    bus.instr_ready = 1'b0;
    do_reset(1);
    repeat (12) @(negedge clk);
    bus.instr_ready  = 1'b1;
    bus.brnch        = 1'b1;
    bus.brnch_target = 8'hFF;
    @(negedge clk);
    bus.brnch = 1'b0;
    check("t5_valid", 32'(bus.instr_valid), 32'd0);
    repeat (12) @(negedge clk);
    check("t5_req2", 32'(req_at(2)), 32'hFF);
    check("t5_req3", 32'(req_at(3)), 32'h00);
    check_cons("t5_c0", 0, 8'hFF, 3'd0, 5'h1F);
    check_cons("t5_c1", 1, 8'h00, 3'd1, 5'd0);

    // 6: async reset with two entries buffered, then mid-request
    bus.instr_ready = 1'b0;
    do_reset(1);
    repeat (12) @(negedge clk);
    check("t6_full_valid", 32'(bus.instr_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("t6_rst_req",   32'(bus.mem_req),     32'd0);
    check("t6_rst_pc",    32'(bus.instr_pc),    32'd0);
    req_log.delete();
    cons_log.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_restart_req0", 32'(req_at(0)), 32'h00);
    check_cons("t6_c0", 0, 8'h00, 3'd1, 5'd0);
    wait_req(8'h05);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_mid_req",   32'(bus.mem_req),     32'd0);
    check("t6_mid_valid", 32'(bus.instr_valid), 32'd0);
    req_log.delete();
    cons_log.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_mid_req0", 32'(req_at(0)), 32'h00);
    check_cons("t6_mid_c0", 0, 8'h00, 3'd1, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
